display_update_ctrl: RTL and testbench
======================================

Name: display_update_ctrl

Overview:
- Sequences refreshes of the serial 7-segment output path (BCD→7seg→48-bit shift register).
- Collects update requests from three sources: time-changed strobe, periodic refresh tick, and forced update from the button/config logic.
- Coalesces requests and snapshots the time/decimal-point/enable values so the data stays stable for a whole shift.
- Issues exactly one start strobe per transfer and watches the shifter's busy flag for completion or hang.

Parameters:
- SYS_CLK_HZ, 50_000_000, system clock frequency.
- REFRESH_HZ, 10, periodic refresh rate. Divider DIV = SYS_CLK_HZ/REFRESH_HZ, which must be ≥2.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed in the WAIT_BUSY and WAIT_DONE states combined. Must be ≥ (48+4)·SYS_CLK_HZ/SHIFT_CLK_HZ.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_time_stb  in  1  one-cycle pulse: time registers changed
- i_force_stb  in  1  one-cycle pulse: update now
- i_en  in  1  display enable (0 = blank)
- i_time_bcd  in  24  {h_msb,h_lsb,m_msb,m_lsb,s_msb,s_lsb}, 4 bits each
- i_dp  in  6  {hours1,hours2,minutes1,minutes2,seconds1,seconds2}
- i_busy  in  1  busy flag from the output shifter
- o_start_stb  out  1  one-cycle start to the shifter
- o_time_bcd  out  24  snapshot driving the shifter data inputs
- o_dp  out  6  snapshot of i_dp
- o_en  out  1  snapshot of i_en
- o_pending  out  1  a request is waiting
- o_fault  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE; pending = 0; refresh counter = 0; timeout counter = 0.
  - o_start_stb = 0, o_time_bcd = 0, o_dp = 0, o_en = 0, o_pending = 0, o_fault = 0.
  - Reset mid-transfer abandons the transfer with no further strobes.
- Refresh tick:
  - Counter runs 0..DIV-1 and wraps.
  - A one-cycle tick is generated on wrap.
- Request:
  - req = i_time_stb | i_force_stb | tick | (i_en != o_en).
  - pending is set by req and cleared only when a transfer is launched.
  - Any number of requests before launch coalesce into one transfer.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If (pending | req) & !i_busy: load o_time_bcd/o_dp/o_en from the inputs in that same cycle's values, clear pending, go to START.
  - If i_busy=1 (foreign or leftover transfer), stay in IDLE with pending held.
- START:
  - o_start_stb = 1 for exactly this cycle, so the strobe appears 1 cycle after the launch decision.
  - Go to WAIT_BUSY. Clear the timeout counter.
- WAIT_BUSY:
  - Stay until i_busy=1, then go to WAIT_DONE.
  - This covers the shifter's registered busy latency.
- WAIT_DONE:
  - Stay until i_busy=0, then go to IDLE.
- Request during START/WAIT_*: sets pending and is served on return to IDLE. The snapshot is never modified outside IDLE launch.
- Same-cycle req and launch: the launch consumes it and pending ends at 0.
  - Exception: a req arriving in START/WAIT_* in the same cycle as the WAIT_DONE→IDLE transition leaves pending=1.
- Timeout:
  - The counter increments each cycle in WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES-1 sets o_fault=1 (sticky until reset) and forces IDLE.
  - pending is left unchanged, so a retry follows once i_busy=0.
- o_pending = pending register.
- o_start_stb is registered and glitch-free.
- Snapshot outputs are registered and change only on launch.

Decomposition:
- Package display_ctrl_pkg holds:
  - State encoding (2-bit localparams).
  - BCD field offsets/widths (DIGIT_W=4, NUM_DIGITS=6).
  - DP vector width 6.
- Refresh divider: reuse existing sysclk_divider (i_en=1) with OUT_CLK_HZ=REFRESH_HZ and use its o_clk_overflow as the tick. No new sub-module.

Test Plan:
- Reset release with SYS_CLK_HZ=1000, REFRESH_HZ=100 (DIV=10), no requests, i_busy tied to a shifter model → first o_start_stb about 10 cycles after reset; all outputs 0 before it.
- i_time_stb with i_time_bcd=0x123456, i_dp=6'b010100, i_busy=0 → o_start_stb high exactly 1 cycle later; o_time_bcd=0x123456 and o_dp=6'b010100 in the same cycle.
- Three i_time_stb pulses plus an i_force_stb while the model holds i_busy for 60 cycles → exactly one further o_start_stb, issued after i_busy falls, with the snapshot carrying the latest i_time_bcd.
- i_time_bcd changed to 0x235959 mid-transfer → o_time_bcd stays at the old value until the next launch.
- i_busy never asserted after a start, TIMEOUT_CYCLES=64 → o_fault=1 64 cycles after o_start_stb; FSM back in IDLE; o_fault survives later successful transfers and clears only on reset.
- i_en toggled 1→0 with no other request → one transfer with o_en=0. Asserting i_reset_n low mid-WAIT_DONE → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/display_ctrl_pkg.sv
// Shared encodings and field widths for the display update controller.
// The BCD time word packs six 4-bit digits, hours MSB first.
package display_ctrl_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;
    localparam int TIME_W     = DIGIT_W * NUM_DIGITS;
    localparam int DP_W       = 6;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/sysclk_divider.sv
// Free-running divider: counts 0..DIV-1 and flags the wrap cycle.
// The overflow flag is a one-cycle tick at OUT_CLK_HZ.
module sysclk_divider #(
    parameter int SYS_CLK_HZ = 50_000_000,
    parameter int OUT_CLK_HZ = 10
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    output logic o_clk_overflow
);

    localparam int DIV   = SYS_CLK_HZ / OUT_CLK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign o_clk_overflow = i_en && (count == LAST);

endmodule

// File: rtl/display_update_ctrl.sv
// Coalesces display update requests, snapshots the display data and runs
// one start/busy handshake per transfer with a hang timeout.
module display_update_ctrl
    import display_ctrl_pkg::*;
#(
    parameter int SYS_CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ     = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_time_stb,
    input  logic              i_force_stb,
    input  logic              i_en,
    input  logic [TIME_W-1:0] i_time_bcd,
    input  logic [DP_W-1:0]   i_dp,
    input  logic              i_busy,
    output logic              o_start_stb,
    output logic [TIME_W-1:0] o_time_bcd,
    output logic [DP_W-1:0]   o_dp,
    output logic              o_en,
    output logic              o_pending,
    output logic              o_fault
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The flag lands on the edge where the count would reach TIMEOUT_CYCLES-1.
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 2);

    state_t            state;
    state_t            state_next;
    logic              tick;
    logic              req;
    logic              pending;
    logic              launch;
    logic              timeout;
    logic [TCNT_W-1:0] tcnt;

    sysclk_divider #(
        .SYS_CLK_HZ (SYS_CLK_HZ),
        .OUT_CLK_HZ (REFRESH_HZ)
    ) u_refresh_div (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_en           (1'b1),
        .o_clk_overflow (tick)
    );

    assign req = i_time_stb | i_force_stb | tick | (i_en != o_en);

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if ((pending | req) && !i_busy) begin
                    launch     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tcnt == TCNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else if (i_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_busy) begin
                    state_next = IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            tcnt        <= '0;
            o_start_stb <= 1'b0;
            o_time_bcd  <= '0;
            o_dp        <= '0;
            o_en        <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            state       <= state_next;
            o_start_stb <= launch;
            // A request in the launch cycle is absorbed by that launch.
            if (launch) begin
                pending    <= 1'b0;
                o_time_bcd <= i_time_bcd;
                o_dp       <= i_dp;
                o_en       <= i_en;
            end else if (req) begin
                pending <= 1'b1;
            end
            if (state == START) begin
                tcnt <= '0;
            end else if ((state == WAIT_BUSY || state == WAIT_DONE) && !timeout) begin
                tcnt <= tcnt + 1'b1;
            end
            if (timeout) begin
                o_fault <= 1'b1;
            end
        end
    end

    assign o_pending = pending;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Bench for display_update_ctrl: one instance with a fast refresh for the
// power-up tick, one with a slow refresh for request/snapshot/timeout cases.
module tb_display_update_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // fast-refresh instance (DIV = 10)
    logic        busy_a = 1'b0;
    int          cnt_a  = 0;
    logic        start_a, en_out_a, pending_a, fault_a;
    logic [23:0] bcd_out_a;
    logic [5:0]  dp_out_a;

    // slow-refresh instance (DIV = 1000)
    logic        time_stb, force_stb, en;
    logic [23:0] time_bcd;
    logic [5:0]  dp;
    logic        busy_b = 1'b0;
    int          cnt_b  = 0;
    int          busy_len;
    logic        dead;
    logic        start_b, en_out_b, pending_b, fault_b;
    logic [23:0] bcd_out_b;
    logic [5:0]  dp_out_b;

    int checks = 0;
    int errors = 0;
    int num_starts = 0;
    logic [30:0] exp_q[$];

    display_update_ctrl #(
        .SYS_CLK_HZ(1000), .REFRESH_HZ(100), .TIMEOUT_CYCLES(64)
    ) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_time_stb(1'b0), .i_force_stb(1'b0),
        .i_en(1'b0), .i_time_bcd(24'h0), .i_dp(6'h0), .i_busy(busy_a),
        .o_start_stb(start_a), .o_time_bcd(bcd_out_a), .o_dp(dp_out_a),
        .o_en(en_out_a), .o_pending(pending_a), .o_fault(fault_a)
    );

    display_update_ctrl #(
        .SYS_CLK_HZ(1000), .REFRESH_HZ(1), .TIMEOUT_CYCLES(64)
    ) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_time_stb(time_stb), .i_force_stb(force_stb),
        .i_en(en), .i_time_bcd(time_bcd), .i_dp(dp), .i_busy(busy_b),
        .o_start_stb(start_b), .o_time_bcd(bcd_out_b), .o_dp(dp_out_b),
        .o_en(en_out_b), .o_pending(pending_b), .o_fault(fault_b)
    );

    // shifter models: busy rises the edge after start, held for a set length
    always @(posedge clk) begin
        if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) busy_a <= 1'b0;
        end else if (start_a) begin
            busy_a <= 1'b1;
            cnt_a  <= 4;
        end
    end

    always @(posedge clk) begin
        if (cnt_b > 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) busy_b <= 1'b0;
        end else if (start_b && !dead) begin
            busy_b <= 1'b1;
            cnt_b  <= busy_len;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every start strobe must match the oldest expected snapshot
    always @(negedge clk) begin
        if (rst_n && start_b) begin
            num_starts++;
            check_eq("busy_at_start", 64'(busy_b), 64'(0));
            if (exp_q.size() == 0) begin
                check_eq("unexpected_start", 64'(1), 64'(0));
            end else begin
                check_eq("snapshot", 64'({bcd_out_b, dp_out_b, en_out_b}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_time(input logic [23:0] b, input logic [5:0] d);
        time_bcd = b;
        dp       = d;
        time_stb = 1'b1;
        @(negedge clk);
        time_stb = 1'b0;
    endtask

    task automatic drive_force(input logic [23:0] b, input logic [5:0] d);
        time_bcd  = b;
        dp        = d;
        force_stb = 1'b1;
        @(negedge clk);
        force_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int n;
        int base;
        logic any;

        rst_n = 1'b0; time_stb = 1'b0; force_stb = 1'b0; en = 1'b0;
        time_bcd = '0; dp = '0; busy_len = 8; dead = 1'b0;
        tick_n(3);
        check_eq("reset_outs", 64'({start_b, bcd_out_b, dp_out_b, en_out_b, pending_b, fault_b}), 64'(0));
        rst_n = 1'b1;

        // refresh tick alone launches the first transfer on the wrap
        any = 1'b0;
        first = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (start_a) begin
                first = cyc;
                break;
            end
            any |= |{bcd_out_a, dp_out_a, en_out_a, pending_a, fault_a};
        end
        check_eq("a_quiet_before_start", 64'(any), 64'(0));
        check_eq("a_first_start_cycle", 64'(first), 64'(10));

        // single time strobe, idle shifter
        exp_q.push_back({24'h123456, 6'b010100, 1'b0});
        drive_time(24'h123456, 6'b010100);
        check_eq("stb_latency", 64'(start_b), 64'(1));
        check_eq("pending_after_launch", 64'(pending_b), 64'(0));
        tick_n(20);

        // coalescing during a long transfer, snapshot held mid-transfer
        busy_len = 60;
        exp_q.push_back({24'h010203, 6'b000001, 1'b0});
        drive_time(24'h010203, 6'b000001);
        check_eq("long_stb_latency", 64'(start_b), 64'(1));
        tick_n(5);
        time_bcd = 24'h235959;
        tick_n(3);
        check_eq("snap_hold", 64'(bcd_out_b), 64'h010203);
        base = num_starts;
        drive_time(24'h111111, 6'b000010);
        tick_n(2);
        drive_time(24'h222222, 6'b000100);
        tick_n(2);
        drive_force(24'h235959, 6'b101010);
        tick_n(2);
        drive_time(24'h235959, 6'b101010);
        check_eq("pending_held", 64'(pending_b), 64'(1));
        check_eq("snap_hold2", 64'(bcd_out_b), 64'h010203);
        exp_q.push_back({24'h235959, 6'b101010, 1'b0});
        tick_n(140);
        check_eq("coalesced_once", 64'(num_starts - base), 64'(1));
        check_eq("queue_after_coalesce", 64'(exp_q.size()), 64'(0));

        // shifter never answers: timeout, sticky fault, retry path
        busy_len = 8;
        dead = 1'b1;
        exp_q.push_back({24'h000102, 6'b000011, 1'b0});
        drive_force(24'h000102, 6'b000011);
        check_eq("hang_start", 64'(start_b), 64'(1));
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (fault_b) break;
        end
        check_eq("timeout_cycles", 64'(n), 64'(64));
        check_eq("fault_set", 64'(fault_b), 64'(1));
        check_eq("pending_after_timeout", 64'(pending_b), 64'(0));
        dead = 1'b0;
        exp_q.push_back({24'h050607, 6'b110000, 1'b0});
        drive_time(24'h050607, 6'b110000);
        check_eq("idle_after_timeout", 64'(start_b), 64'(1));
        tick_n(20);
        check_eq("fault_sticky", 64'(fault_b), 64'(1));

        // enable changes alone request a transfer
        exp_q.push_back({24'h050607, 6'b110000, 1'b1});
        en = 1'b1;
        @(negedge clk);
        check_eq("en_rise_start", 64'(start_b), 64'(1));
        tick_n(20);
        base = num_starts;
        exp_q.push_back({24'h050607, 6'b110000, 1'b0});
        en = 1'b0;
        tick_n(20);
        check_eq("en_fall_one", 64'(num_starts - base), 64'(1));
        check_eq("en_fall_o_en", 64'(en_out_b), 64'(0));

        // asynchronous reset in the middle of a transfer
        busy_len = 30;
        exp_q.push_back({24'h121314, 6'b001100, 1'b0});
        drive_force(24'h121314, 6'b001100);
        tick_n(6);
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_outs", 64'({start_b, bcd_out_b, dp_out_b, en_out_b, pending_b, fault_b}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        base = num_starts;
        tick_n(60);
        check_eq("no_strobe_after_reset", 64'(num_starts - base), 64'(0));
        check_eq("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
